// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared defaults and state encoding for the memory arbiter
package mem_ctrl_pkg;

   localparam int ADDR_W    = 14;
   localparam int DATA_W    = 19;
   localparam int MEM_DEPTH = 16001;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic OWN_CPU  = 1'b0;
   localparam logic OWN_PROG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, response and memory-side signals of the arbiter
interface mem_arbiter_if #(
   parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
   parameter int DATA_W = mem_ctrl_pkg::DATA_W
);
   logic              prog_mode;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic              prog_req;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_wdata;
   logic              prog_ack;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              busy;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  prog_mode, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  prog_req, prog_we, prog_addr, prog_wdata, mem_read_data,
      output cpu_ack, prog_ack, rdata, err, busy,
      output mem_address, mem_write_data, mem_read, mem_write
   );

   modport master (
      output prog_mode, cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output prog_req, prog_we, prog_addr, prog_wdata, mem_read_data,
      input  cpu_ack, prog_ack, rdata, err, busy,
      input  mem_address, mem_write_data, mem_read, mem_write
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (CPU / loader) round-robin arbiter for a single-port memory
// One access at a time: IDLE grants, ACCESS touches memory, RESP acks the owner.
module mem_arbiter #(
   parameter int ADDR_W    = mem_ctrl_pkg::ADDR_W,
   parameter int DATA_W    = mem_ctrl_pkg::DATA_W,
   parameter int MEM_DEPTH = mem_ctrl_pkg::MEM_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   import mem_ctrl_pkg::*;

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_ACCESS = ACCESS;
   localparam logic [1:0] S_RESP   = RESP;

   logic [1:0]        state;
   logic              owner;
   logic              last_grant;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              cpu_ack_q;
   logic              prog_ack_q;

   logic cpu_elig;
   logic prog_elig;
   logic pick_prog;
   logic in_range;

   assign cpu_elig  = bus.cpu_req & ~bus.prog_mode;
   assign prog_elig = bus.prog_req;
   // On a tie the port that did not win last time goes first.
   assign pick_prog = prog_elig & (~cpu_elig | (last_grant == OWN_CPU));
   assign in_range  = 32'(lat_addr) < 32'(MEM_DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         owner      <= OWN_CPU;
         last_grant <= OWN_CPU;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cpu_ack_q  <= 1'b0;
         prog_ack_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cpu_elig | prog_elig) begin
                  owner     <= pick_prog ? OWN_PROG : OWN_CPU;
                  lat_we    <= pick_prog ? bus.prog_we    : bus.cpu_we;
                  lat_addr  <= pick_prog ? bus.prog_addr  : bus.cpu_addr;
                  lat_wdata <= pick_prog ? bus.prog_wdata : bus.cpu_wdata;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Out-of-range reads leave rdata at its previous value.
               if (in_range && !lat_we) begin
                  rdata_q <= bus.mem_read_data;
               end
               err_q      <= ~in_range;
               cpu_ack_q  <= (owner == OWN_CPU);
               prog_ack_q <= (owner == OWN_PROG);
               state      <= S_RESP;
            end
            S_RESP: begin
               cpu_ack_q  <= 1'b0;
               prog_ack_q <= 1'b0;
               err_q      <= 1'b0;
               last_grant <= owner;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Strobes decode from state so an asynchronous reset drops them at once.
   assign bus.mem_read       = (state == S_ACCESS) & in_range & ~lat_we;
   assign bus.mem_write      = (state == S_ACCESS) & in_range & lat_we;
   assign bus.mem_address    = lat_addr;
   assign bus.mem_write_data = lat_wdata;
   assign bus.rdata          = rdata_q;
   assign bus.err            = err_q;
   assign bus.cpu_ack        = cpu_ack_q;
   assign bus.prog_ack       = prog_ack_q;
   assign bus.busy           = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
   localparam int AW    = 14;
   localparam int DW    = 19;
   localparam int DEPTH = 16001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   always @(posedge clk) begin
      if (bus.mem_write && int'(bus.mem_address) < DEPTH) mem[bus.mem_address] <= bus.mem_write_data;
   end
   assign bus.mem_read_data = (int'(bus.mem_address) < DEPTH) ? mem[bus.mem_address] : '0;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic bit inr(input logic [AW-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   // Model: a granted transaction spends one cycle touching memory, then one cycle acking.
   int            age = 0;
   bit            m_prog = 1'b0;
   bit            m_we = 1'b0;
   bit            last_prog = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] exp_rdata = '0;
   bit            exp_err = 1'b0;
   int            wr_seen = 0;

   always @(posedge clk) begin
      bit c, p;
      if (rst) begin
         age = 0; last_prog = 1'b0; m_addr = '0; m_wdata = '0; exp_rdata = '0; exp_err = 1'b0;
      end else if (age == 1) begin
         if (inr(m_addr)) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else exp_rdata = ref_mem[m_addr];
         end
         exp_err = !inr(m_addr);
         age = 2;
      end else if (age == 2) begin
         last_prog = m_prog;
         age = 0;
      end else begin
         c = bus.cpu_req && !bus.prog_mode;
         p = bus.prog_req;
         if (c || p) begin
            m_prog  = p && (!c || !last_prog);
            m_we    = m_prog ? bus.prog_we : bus.cpu_we;
            m_addr  = m_prog ? bus.prog_addr : bus.cpu_addr;
            m_wdata = m_prog ? bus.prog_wdata : bus.cpu_wdata;
            age = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.mem_write) wr_seen++;
      if (rst) begin
         chk("rst_busy", bus.busy, 0);
         chk("rst_cpu_ack", bus.cpu_ack, 0);
         chk("rst_prog_ack", bus.prog_ack, 0);
         chk("rst_err", bus.err, 0);
         chk("rst_mem_read", bus.mem_read, 0);
         chk("rst_mem_write", bus.mem_write, 0);
         chk("rst_rdata", bus.rdata, 0);
         chk("rst_mem_address", bus.mem_address, 0);
         chk("rst_mem_write_data", bus.mem_write_data, 0);
      end else begin
         chk("busy", bus.busy, age != 0);
         chk("cpu_ack", bus.cpu_ack, age == 2 && !m_prog);
         chk("prog_ack", bus.prog_ack, age == 2 && m_prog);
         chk("mem_write", bus.mem_write, age == 1 && m_we && inr(m_addr));
         chk("mem_read", bus.mem_read, age == 1 && !m_we && inr(m_addr));
         chk("mem_address", bus.mem_address, m_addr);
         chk("mem_write_data", bus.mem_write_data, m_wdata);
         if (age == 2) begin
            chk("ack_err", bus.err, exp_err);
            chk("ack_rdata", bus.rdata, exp_rdata);
         end
      end
   end

   task automatic wait_ack(input bit prog, output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (prog ? bus.prog_ack : bus.cpu_ack) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, got, acks, busies, w0;
      int order [3];
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      bus.prog_mode = 0; bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.prog_req = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Loader write then CPU read of the same word
      bus.prog_req = 1; bus.prog_we = 1; bus.prog_addr = 14'd5; bus.prog_wdata = 19'h7ABCD;
      wait_ack(1, n);
      chk("s1_prog_latency", n, 3);
      step(); bus.prog_req = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'd5;
      wait_ack(0, n);
      chk("s1_cpu_latency", n, 3);
      chk("s1_rdata", bus.rdata, 19'h7ABCD);
      chk("s1_err", bus.err, 0);
      step(); bus.cpu_req = 0;

      // Round-robin with both held from reset
      rst = 1;
      step(); rst = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'd5;
      bus.prog_req = 1; bus.prog_we = 0; bus.prog_addr = 14'd5;
      order = '{2, 2, 2};
      got = 0;
      for (int i = 0; i < 40 && got < 3; i++) begin
         @(negedge clk);
         if (bus.prog_ack) begin order[got] = 1; got++; end
         else if (bus.cpu_ack) begin order[got] = 0; got++; end
      end
      chk("s2_grant0_prog", order[0], 1);
      chk("s2_grant1_cpu", order[1], 0);
      chk("s2_grant2_prog", order[2], 1);
      step(); bus.cpu_req = 0; bus.prog_req = 0;
      repeat (3) step();

      // prog_mode holds the CPU off
      bus.prog_mode = 1; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'd5;
      acks = 0; busies = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.cpu_ack) acks++;
         if (bus.busy) busies++;
      end
      chk("s3_no_cpu_ack", acks, 0);
      chk("s3_not_busy", busies, 0);
      step(); bus.prog_mode = 0;
      wait_ack(0, n);
      chk("s3_latency", n, 3);
      chk("s3_rdata", bus.rdata, 19'h7ABCD);
      step(); bus.cpu_req = 0;

      // Out-of-range write
      w0 = wr_seen;
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'd16001; bus.cpu_wdata = 19'h12345;
      wait_ack(0, n);
      chk("s4_ack_seen", n, 3);
      chk("s4_err", bus.err, 1);
      chk("s4_rdata_held", bus.rdata, 19'h7ABCD);
      chk("s4_no_mem_write", wr_seen - w0, 0);
      step(); bus.cpu_req = 0;

      // Reset in the middle of a write access
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'd7; bus.cpu_wdata = 19'h01111;
      step();
      chk("s5_write_in_access", bus.mem_write, 1);
      rst = 1; bus.cpu_req = 0;
      #1;
      chk("s5_write_dropped", bus.mem_write, 0);
      step(); rst = 0;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.cpu_ack || bus.prog_ack) acks++;
      end
      chk("s5_no_ack", acks, 0);
      chk("s5_busy_after", bus.busy, 0);
      chk("s5_mem_untouched", mem[7], 0);

      // Upper boundary address
      step();
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 14'd16000; bus.cpu_wdata = 19'h00001;
      wait_ack(0, n);
      chk("s6_wr_latency", n, 3);
      chk("s6_wr_err", bus.err, 0);
      step(); bus.cpu_req = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 14'd16000;
      wait_ack(0, n);
      chk("s6_rd_latency", n, 3);
      chk("s6_rdata", bus.rdata, 19'h00001);
      chk("s6_rd_err", bus.err, 0);
      step(); bus.cpu_req = 0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory address width.
REQ-002 SHALL have parameter DATA_W, default 19, memory word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 16001, number of valid words (addresses 0..MEM_DEPTH-1).
REQ-004 SHALL have the following ports; there is one clock and reset is asynchronous and active-high:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous active-high reset
  prog_mode  in  1  loader-only mode; CPU requests are held off
  cpu_req  in  1  CPU access request, held until cpu_ack
  cpu_we  in  1  1=write, 0=read
  cpu_addr  in  ADDR_W  CPU address
  cpu_wdata  in  DATA_W  CPU write data
  cpu_ack  out  1  one-cycle completion pulse to CPU
  prog_req  in  1  loader access request, held until prog_ack
  prog_we  in  1  1=write, 0=read
  prog_addr  in  ADDR_W  loader address
  prog_wdata  in  DATA_W  loader write data
  prog_ack  out  1  one-cycle completion pulse to loader
  rdata  out  DATA_W  registered read data, valid with the ack
  err  out  1  out-of-range flag, valid with the ack
  busy  out  1  high when the state is not IDLE
  mem_address  out  ADDR_W  to memory
  mem_write_data  out  DATA_W  to memory
  mem_read  out  1  to memory
  mem_write  out  1  to memory
  mem_read_data  in  DATA_W  combinational read data from memory

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-006 In IDLE with at least one eligible request, SHALL on the clock edge:
  - select the owner;
  - latch its we, addr and wdata;
  - go to ACCESS.
  With no eligible request it SHALL stay in IDLE.
REQ-007 cpu_req SHALL be eligible only when prog_mode=0; prog_req SHALL always be eligible.
REQ-008 When both requests are eligible, SHALL grant the port not granted last (round-robin); last_grant SHALL reset to CPU, so the loader wins the first tie.
REQ-009 In ACCESS, for an in-range write, mem_write SHALL be 1 for exactly that cycle, with mem_address and mem_write_data driven from the latched values.
REQ-010 In ACCESS, for an in-range read, mem_read SHALL be 1 and rdata SHALL capture mem_read_data at the end of the cycle.
REQ-011 An address >= MEM_DEPTH SHALL NOT assert mem_read or mem_write; err SHALL be 1 in RESP and rdata SHALL hold its previous value.
REQ-012 ACCESS SHALL always go to RESP after one cycle.
REQ-013 In RESP, SHALL pulse the owner's ack for one cycle, update last_grant, and return to IDLE.
REQ-014 Latency: request sampled at edge N; ACCESS in cycle N+1; ack high in cycle N+2; a back-to-back grant is possible from the edge ending cycle N+2.
REQ-015 A requester that still has req high in the cycle after its ack SHALL be treated as a new request.
REQ-016 Outside ACCESS, mem_read and mem_write SHALL be 0, and mem_address/mem_write_data SHALL hold the latched values.
REQ-017 prog_mode rising during ACCESS or RESP SHALL NOT abort an in-flight CPU access.
REQ-018 cpu_ack and prog_ack SHALL never be high in the same cycle.

Reset
REQ-019 While rst=1, SHALL hold:
  - state=IDLE;
  - cpu_ack, prog_ack, err, busy, mem_read, mem_write = 0;
  - rdata, mem_address, mem_write_data = 0;
  - last_grant=CPU.
REQ-020 Reset asserted mid-ACCESS SHALL drop mem_write immediately (asynchronously) and SHALL produce no ack after release.

Structure
REQ-021 Package mem_ctrl_pkg SHALL hold ADDR_W, DATA_W, MEM_DEPTH defaults and the state enum {IDLE, ACCESS, RESP}.
REQ-022 SHALL be a single flat module; the memory array SHALL be instantiated beside it, not inside it.

Verification
REQ-023 Scenario: prog write addr 5, data 19'h7ABCD; then CPU read addr 5 -> prog_ack at N+2; CPU sees cpu_ack with rdata=19'h7ABCD, err=0.
REQ-024 Scenario: both request after reset -> prog granted first, cpu second; both held continuously -> grants alternate prog, cpu, prog.
REQ-025 Scenario: prog_mode=1 with cpu_req held 10 cycles -> no cpu_ack; drop prog_mode -> cpu_ack 2 cycles later.
REQ-026 Scenario: CPU write to addr 16001 -> mem_write never 1; cpu_ack with err=1; rdata unchanged.
REQ-027 Scenario: rst pulsed in ACCESS of a write -> mem_write falls the same cycle; no ack; busy=0 after release.
REQ-028 Scenario: CPU write addr 16000, data 19'h00001, then read back -> rdata=19'h00001, err=0 (upper boundary).
